decoder_scan_sequencer: RTL
===========================

DECODER_SCAN_SEQUENCER -- requirements
Module: decoder_scan_sequencer

Interface
REQ-001 Parameter DWELL_W, default 8, width of the dwell-count input and internal dwell counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin a scan; sampled only in IDLE.
REQ-005 Stop  input  1  abort request; sampled in SCAN and IDLE.
REQ-006 Mode  input  1  0 = single sweep, 1 = continuous; latched on accepted Start.
REQ-007 Dir  input  1  0 = ascending (0->7), 1 = descending (7->0); latched on accepted Start.
REQ-008 Dwell  input  DWELL_W  each address held Dwell+1 cycles; latched on accepted Start.
REQ-009 A  output  3  address to the downstream 3-to-8 decoder select input, registered.
REQ-010 Enable  output  1  drives downstream decoder enable, registered.
REQ-011 Busy  output  1  high while in SCAN, registered.
REQ-012 Done  output  1  one-cycle pulse on single-sweep completion, registered.

Function
REQ-013 Three states: IDLE, SCAN, FINISH; all outputs are registered, no combinational input-to-output path.
REQ-014 IDLE: Enable=0, Busy=0, Done=0, A holds last value.
REQ-015 IDLE, Start=1, Stop=0 at edge k -> SCAN after edge k; A=0 (Dir=0) or 7 (Dir=1), Enable=1, Busy=1, dwell counter = Dwell.
REQ-016 IDLE, Start=1 and Stop=1 same edge -> Stop wins, remain IDLE, no output change.
REQ-017 SCAN: dwell counter decrements by 1 each cycle while nonzero; A constant meanwhile.
REQ-018 SCAN, counter=0, A not terminal (7 ascending / 0 descending) -> A steps +1 or -1, counter reloads latched Dwell.
REQ-019 SCAN, counter=0, A terminal, latched Mode=1 -> A wraps (7->0 or 0->7), counter reloads, remain SCAN.
REQ-020 SCAN, counter=0, A terminal, latched Mode=0 -> FINISH; Enable=0, Busy=0, Done=1, A holds terminal value.
REQ-021 FINISH lasts exactly one cycle, then IDLE with Done=0; Start during FINISH is ignored.
REQ-022 Stop=1 in SCAN at any edge -> IDLE after that edge; Enable=0, Busy=0, Done stays 0, A holds current value; Stop has priority over step/wrap/finish on the same edge.
REQ-023 Start during SCAN ignored; Mode, Dir, Dwell changes during SCAN have no effect until next accepted Start.
REQ-024 Single sweep timing: Enable high for exactly 8*(Dwell+1) consecutive cycles, Done high in the next cycle.
REQ-025 Dwell=0: address advances every cycle; Dwell=2^DWELL_W-1: each address held 2^DWELL_W cycles, no counter overflow.
REQ-026 Each address appears exactly once per sweep, in strict order, no skipped or repeated addresses.

Reset
REQ-027 reset=1 at a rising edge -> IDLE, A=0, Enable=0, Busy=0, Done=0, dwell counter=0, latched Mode/Dir/Dwell=0.
REQ-028 reset has priority over Start, Stop and all state transitions, including mid-SCAN and in FINISH.
REQ-029 First Start accepted on the first edge with reset=0.

Verification
REQ-030 Mode=0, Dir=0, Dwell=0, Start pulse -> A = 0,1,...,7 one per cycle, Enable high 8 cycles, Done=1 for 1 cycle, then IDLE with A=7.
REQ-031 Mode=0, Dir=1, Dwell=2, Start -> A = 7..0, each held 3 cycles, Enable high 24 cycles, Done pulse after, A=0 at end.
REQ-032 Mode=1, Dir=0, Dwell=1 -> sequence 0..7,0,1,... each held 2 cycles, Busy stays 1, Done never asserted; Stop while A=3 -> next cycle Enable=0, Busy=0, A=3, Done=0.
REQ-033 Start and Stop asserted together in IDLE -> outputs unchanged, remain IDLE; Start pulsed mid-SCAN -> sequence undisturbed.
REQ-034 reset asserted mid-SCAN at A=5 -> next cycle A=0, Enable=0, Busy=0, Done=0; a following Start runs a full normal sweep.
REQ-035 Dwell changed from 1 to 4 mid-SCAN -> current scan keeps 2-cycle hold; next Start uses 5-cycle hold.

Source files
------------

// File: rtl/decoder_scan_sequencer.sv
// Address sequencer for a downstream 3-to-8 decoder. It sweeps A up or down,
// holds each address for a programmable dwell time, and runs either one sweep or continuously.
`timescale 1ns/1ps

module decoder_scan_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Start,
   input  logic               Stop,
   input  logic               Mode,
   input  logic               Dir,
   input  logic [DWELL_W-1:0] Dwell,
   output logic [2:0]         A,
   output logic               Enable,
   output logic               Busy,
   output logic               Done
);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      FINISH
   } stateT;

   stateT              state, stateNext;
   logic [DWELL_W-1:0] dwellCount, dwellCountNext;
   logic [DWELL_W-1:0] dwellLat, dwellLatNext;
   logic               modeLat, modeLatNext;
   logic               dirLat, dirLatNext;
   logic [2:0]         aNext;
   logic               enableNext;
   logic               busyNext;
   logic               doneNext;
   logic               atTerminal;
   logic [2:0]         steppedAddr;

   // Stepping and wrapping share one modulo-8 add/subtract.
   assign atTerminal  = dirLat ? (A == 3'd0) : (A == 3'd7);
   assign steppedAddr = dirLat ? (A - 3'd1) : (A + 3'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         A          <= 3'd0;
         Enable     <= 1'b0;
         Busy       <= 1'b0;
         Done       <= 1'b0;
         dwellCount <= '0;
         dwellLat   <= '0;
         modeLat    <= 1'b0;
         dirLat     <= 1'b0;
      end else begin
         state      <= stateNext;
         A          <= aNext;
         Enable     <= enableNext;
         Busy       <= busyNext;
         Done       <= doneNext;
         dwellCount <= dwellCountNext;
         dwellLat   <= dwellLatNext;
         modeLat    <= modeLatNext;
         dirLat     <= dirLatNext;
      end
   end

   always_comb begin
      stateNext      = state;
      aNext          = A;
      enableNext     = Enable;
      busyNext       = Busy;
      doneNext       = 1'b0;
      dwellCountNext = dwellCount;
      dwellLatNext   = dwellLat;
      modeLatNext    = modeLat;
      dirLatNext     = dirLat;

      case (state)
         IDLE: begin
            enableNext = 1'b0;
            busyNext   = 1'b0;
            if (Start && !Stop) begin
               stateNext      = SCAN;
               aNext          = Dir ? 3'd7 : 3'd0;
               enableNext     = 1'b1;
               busyNext       = 1'b1;
               dwellCountNext = Dwell;
               dwellLatNext   = Dwell;
               modeLatNext    = Mode;
               dirLatNext     = Dir;
            end
         end

         SCAN: begin
            // Stop outranks every counting, stepping and finishing action.
            if (Stop) begin
               stateNext  = IDLE;
               enableNext = 1'b0;
               busyNext   = 1'b0;
            end else if (dwellCount != '0) begin
               dwellCountNext = dwellCount - DWELL_W'(1);
            end else if (!atTerminal || modeLat) begin
               aNext          = steppedAddr;
               dwellCountNext = dwellLat;
            end else begin
               stateNext  = FINISH;
               enableNext = 1'b0;
               busyNext   = 1'b0;
               doneNext   = 1'b1;
            end
         end

         FINISH: begin
            stateNext  = IDLE;
            enableNext = 1'b0;
            busyNext   = 1'b0;
         end

         default: begin
            stateNext  = IDLE;
            enableNext = 1'b0;
            busyNext   = 1'b0;
         end
      endcase
   end

endmodule
